// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv shared constants: SPECIAL decode values,
// controller state encoding and divider iteration count.
package ex_muldiv_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] F_MTHI     = 6'h11;
    localparam logic [5:0] F_MTLO     = 6'h13;
    localparam logic [5:0] F_MULT     = 6'h18;
    localparam logic [5:0] F_MULTU    = 6'h19;
    localparam logic [5:0] F_DIV      = 6'h1A;
    localparam logic [5:0] F_DIVU     = 6'h1B;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage operand bundle into the mul/div unit and
// the HI/LO/busy results back out.
interface ex_muldiv_if;

    logic [31:0] instrE;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output instrE, rd1E, rd2E,
        input  hi, lo, busy
    );

    modport slave (
        input  instrE, rd1E, rd2E,
        output hi, lo, busy
    );

endinterface

// File: rtl/ex_muldiv_divcore.sv
// Restoring unsigned divider: one quotient bit per step,
// operands are magnitudes; sign handling lives in the controller.
module muldiv_divcore (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        borrow;
    logic        ge;

    // 33-bit partial remainder vs divisor; bit 32 set means it always fits
    assign shifted        = {rem, quo[31]};
    assign {borrow, diff} = {1'b0, shifted[31:0]} - {1'b0, dsr};
    assign ge             = shifted[32] | ~borrow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            dsr <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dsr <= divisor;
        end else if (step) begin
            rem <= ge ? diff : shifted[31:0];
            quo <= {quo[30:0], ge};
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide controller owning HI/LO.
// Multiply is captured at accept and released after MULT_CYCLES.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_ITERS - 1);

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [63:0] prod, prod_n;
    logic [31:0] hi_q, lo_q, a_raw;
    logic        a_neg, q_neg, dz;

    logic [31:0] a, b;
    logic [5:0]  funct;
    logic        special;
    logic        is_mthi, is_mtlo, is_mul, is_div;
    logic        mul_signed, div_signed;
    logic [31:0] a_mag, b_mag;
    logic [31:0] quo, rem;
    logic        unused_instr;

    logic acc_mthi, acc_mtlo, acc_mul, acc_div;
    logic step, mul_done, div_done;

    assign a       = bus.rd1E;
    assign b       = bus.rd2E;
    assign funct   = bus.instrE[5:0];
    assign special = bus.instrE[31:26] == OP_SPECIAL;
    assign unused_instr = ^bus.instrE[25:6];

    assign is_mthi = special && funct == F_MTHI;
    assign is_mtlo = special && funct == F_MTLO;
    assign is_mul  = special && (funct == F_MULT || funct == F_MULTU);
    assign is_div  = special && (funct == F_DIV || funct == F_DIVU);

    assign mul_signed = funct == F_MULT;
    assign div_signed = funct == F_DIV;

    assign prod_n = {{32{mul_signed & a[31]}}, a}
                  * {{32{mul_signed & b[31]}}, b};

    assign a_mag = (div_signed && a[31]) ? -a : a;
    assign b_mag = (div_signed && b[31]) ? -b : b;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_mthi = 1'b0;
        acc_mtlo = 1'b0;
        acc_mul  = 1'b0;
        acc_div  = 1'b0;
        step     = 1'b0;
        mul_done = 1'b0;
        div_done = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    is_mthi: acc_mthi = 1'b1;
                    is_mtlo: acc_mtlo = 1'b1;
                    is_mul: begin
                        acc_mul = 1'b1;
                        state_n = MUL;
                        cnt_n   = MUL_LOAD;
                    end
                    is_div: begin
                        acc_div = 1'b1;
                        state_n = DIV;
                        cnt_n   = DIV_LOAD;
                    end
                    default: ;
                endcase
            end
            MUL: begin
                if (cnt == '0) begin
                    mul_done = 1'b1;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt - 5'd1;
                end
            end
            DIV: begin
                step = 1'b1;
                if (cnt == '0) state_n = FIX;
                else           cnt_n   = cnt - 5'd1;
            end
            FIX: begin
                div_done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            prod  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            a_raw <= '0;
            a_neg <= 1'b0;
            q_neg <= 1'b0;
            dz    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (acc_mul) prod <= prod_n;
            if (acc_div) begin
                a_raw <= a;
                a_neg <= div_signed & a[31];
                q_neg <= div_signed & (a[31] ^ b[31]);
                dz    <= b == '0;
            end
            if (acc_mthi) hi_q <= a;
            if (acc_mtlo) lo_q <= a;
            if (mul_done) {hi_q, lo_q} <= prod;
            if (div_done) begin
                if (dz) begin
                    hi_q <= a_raw;
                    lo_q <= '1;
                end else begin
                    hi_q <= a_neg ? -rem : rem;
                    lo_q <= q_neg ? -quo : quo;
                end
            end
        end
    end

    muldiv_divcore u_divcore (
        .clk       (clk),
        .rst       (rst),
        .load      (acc_div),
        .step      (step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = state != IDLE;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed cases plus random ops
// against an arithmetic HI/LO reference model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int MC = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if bus ();

    ex_muldiv #(.MULT_CYCLES(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] f);
        return {26'b0, f};
    endfunction

    function automatic int exp_busy(input logic [31:0] ins);
        if (ins[31:26] != 6'h0) return 0;
        if (ins[5:0] == F_MULT || ins[5:0] == F_MULTU) return MC;
        if (ins[5:0] == F_DIV || ins[5:0] == F_DIVU) return 33;
        return 0;
    endfunction

    task automatic model(input logic [31:0] ins,
                         input logic [31:0] a,
                         input logic [31:0] b);
        int sa, sb;
        longint p;
        longint unsigned pu;
        sa = $signed(a);
        sb = $signed(b);
        if (ins[31:26] == 6'h0) begin
            case (ins[5:0])
                F_MTHI: m_hi = a;
                F_MTLO: m_lo = a;
                F_MULT: begin
                    p = longint'(sa) * longint'(sb);
                    {m_hi, m_lo} = p;
                end
                F_MULTU: begin
                    pu = longint'(a) * longint'(b);
                    {m_hi, m_lo} = pu;
                end
                F_DIVU: begin
                    if (b == 0) begin m_lo = '1; m_hi = a; end
                    else begin m_lo = a / b; m_hi = a % b; end
                end
                F_DIV: begin
                    if (b == 0) begin
                        m_lo = '1; m_hi = a;
                    end else if (a == 32'h80000000 && b == '1) begin
                        m_lo = 32'h80000000; m_hi = 0;
                    end else begin
                        m_lo = sa / sb; m_hi = sa % sb;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [31:0] ins,
                          input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] ph, pl;
        int n;
        bit stable;
        @(negedge clk);
        bus.instrE = ins;
        bus.rd1E   = a;
        bus.rd2E   = b;
        ph = m_hi;
        pl = m_lo;
        stable = 1;
        n = 0;
        @(negedge clk);
        bus.instrE = '0;
        bus.rd1E   = $urandom;
        bus.rd2E   = $urandom;
        while (bus.busy && n < 100) begin
            n++;
            if (bus.hi !== ph || bus.lo !== pl) stable = 0;
            @(negedge clk);
        end
        model(ins, a, b);
        check({tag, " busy"}, 64'(n), 64'(exp_busy(ins)));
        check({tag, " stable"}, 64'(stable), 64'd1);
        check({tag, " hi"}, {32'b0, bus.hi}, {32'b0, m_hi});
        check({tag, " lo"}, {32'b0, bus.lo}, {32'b0, m_lo});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] s [5];
        s = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h7FFFFFFF};
        if ($urandom_range(0, 3) == 0) return s[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    initial begin
        logic [5:0] ops [6];
        logic [31:0] ins;
        ops = '{F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
        rst = 1'b1;
        bus.instrE = '0;
        bus.rd1E   = '0;
        bus.rd2E   = '0;
        m_hi = '0;
        m_lo = '0;
        #1;
        check("reset hi", {32'b0, bus.hi}, 64'd0);
        check("reset lo", {32'b0, bus.lo}, 64'd0);
        check("reset busy", {63'b0, bus.busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mult", mk(F_MULT), 32'hFFFFFFFE, 32'h3);
        run_op("multu", mk(F_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("div -7/2", mk(F_DIV), 32'hFFFFFFF9, 32'h2);
        run_op("divu 100/7", mk(F_DIVU), 32'd100, 32'd7);
        run_op("divu by0", mk(F_DIVU), 32'h64, 32'h0);
        run_op("div by0", mk(F_DIV), 32'hFFFFFFF9, 32'h0);
        run_op("div ovf", mk(F_DIV), 32'h80000000, 32'hFFFFFFFF);
        run_op("noop op", {6'h01, 20'h0, F_MULT}, 32'h5, 32'h6);

        // back-to-back MTHI/MTLO, one edge each
        @(negedge clk);
        bus.instrE = mk(F_MTHI);
        bus.rd1E   = 32'h1234;
        @(negedge clk);
        check("mthi hi", {32'b0, bus.hi}, 64'h1234);
        check("mthi lo", {32'b0, bus.lo}, {32'b0, m_lo});
        check("mthi busy", {63'b0, bus.busy}, 64'd0);
        bus.instrE = mk(F_MTLO);
        bus.rd1E   = 32'h5678;
        @(negedge clk);
        bus.instrE = '0;
        m_hi = 32'h1234;
        m_lo = 32'h5678;
        check("mtlo hi", {32'b0, bus.hi}, 64'h1234);
        check("mtlo lo", {32'b0, bus.lo}, 64'h5678);
        check("mtlo busy", {63'b0, bus.busy}, 64'd0);

        // MTLO while DIV busy is ignored
        @(negedge clk);
        bus.instrE = mk(F_DIV);
        bus.rd1E   = 32'd1000;
        bus.rd2E   = 32'hFFFFFFFD;
        @(negedge clk);
        bus.instrE = mk(F_MTLO);
        bus.rd1E   = 32'hDEAD;
        repeat (3) @(negedge clk);
        bus.instrE = '0;
        begin
            int n = 0;
            while (bus.busy && n < 100) begin n++; @(negedge clk); end
        end
        model(mk(F_DIV), 32'd1000, 32'hFFFFFFFD);
        check("busy-mtlo lo", {32'b0, bus.lo}, {32'b0, m_lo});
        check("busy-mtlo hi", {32'b0, bus.hi}, {32'b0, m_hi});

        // op held while busy falls: accepted one edge later
        @(negedge clk);
        bus.instrE = mk(F_MULT);
        bus.rd1E   = 32'h00010001;
        bus.rd2E   = 32'hFFFF0000;
        @(negedge clk);
        bus.instrE = mk(F_MTHI);
        bus.rd1E   = 32'hABCD;
        begin
            int n = 0;
            while (bus.busy && n < 100) begin n++; @(negedge clk); end
            check("hold busy", 64'(n), 64'(MC));
        end
        model(mk(F_MULT), 32'h00010001, 32'hFFFF0000);
        check("hold prod hi", {32'b0, bus.hi}, {32'b0, m_hi});
        check("hold prod lo", {32'b0, bus.lo}, {32'b0, m_lo});
        @(negedge clk);
        bus.instrE = '0;
        m_hi = 32'hABCD;
        check("hold mthi", {32'b0, bus.hi}, 64'hABCD);

        for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(0, 6);
            if (k == 6) ins = {6'($urandom_range(1, 63)), 20'h0, F_DIVU};
            else        ins = mk(ops[k]);
            run_op($sformatf("rnd%0d f%h", i, ins[5:0]), ins, pick(), pick());
        end

        // async reset in the middle of a divide
        @(negedge clk);
        bus.instrE = mk(F_DIV);
        bus.rd1E   = 32'hFFFFFFF9;
        bus.rd2E   = 32'h2;
        @(negedge clk);
        bus.instrE = '0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst hi", {32'b0, bus.hi}, 64'd0);
        check("rst lo", {32'b0, bus.lo}, 64'd0);
        check("rst busy", {63'b0, bus.busy}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op("post-rst mult", mk(F_MULT), 32'd3, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
